// File: rtl/perceptron_trainer_pkg.sv
// Shared widths, FSM state encoding and weight saturation limits for the perceptron trainer.
package perceptron_trainer_pkg;

  localparam int XW   = 4;
  localparam int WW   = 6;
  localparam int WMAX = (2 ** (WW - 1)) - 1;
  localparam int WMIN = -(2 ** (WW - 1));

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    UPDATE,
    RESP
  } state_e;

endpackage

// File: rtl/perceptron_trainer_if.sv
// Sample-in / result-out handshake bundle of the perceptron trainer.
interface perceptron_trainer_if #(
  parameter int XW = perceptron_trainer_pkg::XW
) ();

  logic          s_valid;
  logic          s_ready;
  logic [XW-1:0] s_x0;
  logic [XW-1:0] s_x1;
  logic          s_target;
  logic          o_valid;
  logic          o_ready;
  logic          o_y;
  logic          o_miss;

  modport master (
    output s_valid, s_x0, s_x1, s_target, o_ready,
    input  s_ready, o_valid, o_y, o_miss
  );

  modport slave (
    input  s_valid, s_x0, s_x1, s_target, o_ready,
    output s_ready, o_valid, o_y, o_miss
  );

endinterface

// File: rtl/perceptron_trainer_sat_add.sv
// Signed DW-bit weight plus signed IW-bit increment, clamped to [MINV, MAXV].
module perceptron_trainer_sat_add
  import perceptron_trainer_pkg::*;
#(
  parameter int DW   = WW,
  parameter int IW   = XW + 1,
  parameter int MAXV = WMAX,
  parameter int MINV = WMIN
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [IW-1:0] inc_i,
  output logic signed [DW-1:0] sum_o
);

  localparam int EW = ((DW > IW) ? DW : IW) + 1;

  function automatic logic signed [DW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > EW'(MAXV))      return DW'(MAXV);
    else if (v < EW'(MINV)) return DW'(MINV);
    else                    return DW'(v);
  endfunction

  logic signed [EW-1:0] ext_sum;

  always_comb begin
    ext_sum = EW'(a_i) + EW'(inc_i);
    sum_o   = sat(ext_sum);
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: IDLE -> MAC -> UPDATE -> RESP per sample, weights exported live.
// Optional macro TRAINER_WEIGHT_LOAD_EN adds ld_en/ld_w0/ld_w1/ld_bias for direct weight loading.
module perceptron_trainer #(
  parameter int XW         = perceptron_trainer_pkg::XW,
  parameter int WW         = perceptron_trainer_pkg::WW,
  parameter int THRESH     = 6,
  parameter int W0_INIT    = 2,
  parameter int W1_INIT    = 1,
  parameter int BIAS_INIT  = 1,
  parameter int CONV_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  perceptron_trainer_if.slave  bus,
  input  logic                 freeze,
`ifdef TRAINER_WEIGHT_LOAD_EN
  input  logic                 ld_en,
  input  logic signed [WW-1:0] ld_w0,
  input  logic signed [WW-1:0] ld_w1,
  input  logic signed [WW-1:0] ld_bias,
`endif
  output logic signed [WW-1:0] w0_out,
  output logic signed [WW-1:0] w1_out,
  output logic signed [WW-1:0] bias_out,
  output logic                 converged,
  output logic [7:0]           err_cnt
);

  import perceptron_trainer_pkg::*;

  localparam int SW  = WW + XW + 2;
  localparam int STW = $clog2(CONV_COUNT + 1);
  localparam logic signed [SW-1:0] THR = SW'(THRESH);

  state_e               state_q;
  logic [XW-1:0]        x0_q, x1_q;
  logic                 tgt_q;
  logic signed [SW-1:0] sum_q, sum_d;
  logic signed [WW-1:0] w0_q, w1_q, bias_q;
  logic signed [WW-1:0] w0_d, w1_d, bias_d;
  logic signed [XW:0]   inc0, inc1, incb;
  logic                 y_d, miss_d, load_req;
  logic                 ovld_q, y_q, miss_q, conv_q;
  logic [STW-1:0]       streak_q, streak_d;
  logic [7:0]           err_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef TRAINER_WEIGHT_LOAD_EN
  assign load_req = ld_en;
`else
  assign load_req = 1'b0;
`endif

  // x is zero-extended so the products stay signed; SW bits cannot overflow
  always_comb begin
    sum_d    = SW'(w0_q) * SW'($signed({1'b0, x0_q}))
             + SW'(w1_q) * SW'($signed({1'b0, x1_q}))
             + SW'(bias_q);
    y_d      = (sum_q > THR);
    miss_d   = (y_d != tgt_q);
    inc0     = tgt_q ? $signed({1'b0, x0_q}) : -$signed({1'b0, x0_q});
    inc1     = tgt_q ? $signed({1'b0, x1_q}) : -$signed({1'b0, x1_q});
    incb     = tgt_q ? (XW+1)'(1) : -((XW+1)'(1));
    streak_d = (streak_q == STW'(CONV_COUNT)) ? streak_q : streak_q + STW'(1);
  end

  perceptron_trainer_sat_add #(.DW(WW), .IW(XW + 1), .MAXV((2 ** (WW - 1)) - 1), .MINV(-(2 ** (WW - 1))))
    u_sat_w0 (.a_i(w0_q), .inc_i(inc0), .sum_o(w0_d));
  perceptron_trainer_sat_add #(.DW(WW), .IW(XW + 1), .MAXV((2 ** (WW - 1)) - 1), .MINV(-(2 ** (WW - 1))))
    u_sat_w1 (.a_i(w1_q), .inc_i(inc1), .sum_o(w1_d));
  perceptron_trainer_sat_add #(.DW(WW), .IW(XW + 1), .MAXV((2 ** (WW - 1)) - 1), .MINV(-(2 ** (WW - 1))))
    u_sat_b (.a_i(bias_q), .inc_i(incb), .sum_o(bias_d));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      w0_q     <= WW'(W0_INIT);
      w1_q     <= WW'(W1_INIT);
      bias_q   <= WW'(BIAS_INIT);
      ovld_q   <= 1'b0;
      y_q      <= 1'b0;
      miss_q   <= 1'b0;
      streak_q <= '0;
      conv_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_req) begin
`ifdef TRAINER_WEIGHT_LOAD_EN
            w0_q   <= ld_w0;
            w1_q   <= ld_w1;
            bias_q <= ld_bias;
`endif
            streak_q <= '0;
            conv_q   <= 1'b0;
          end else if (bus.s_valid) begin
            x0_q    <= bus.s_x0;
            x1_q    <= bus.s_x1;
            tgt_q   <= bus.s_target;
            state_q <= MAC;
          end
        end
        MAC: begin
          sum_q   <= sum_d;
          state_q <= UPDATE;
        end
        // freeze only matters here: learning and counters are both gated by it
        UPDATE: begin
          y_q     <= y_d;
          miss_q  <= miss_d;
          ovld_q  <= 1'b1;
          state_q <= RESP;
          if (!freeze) begin
            if (miss_d) begin
              w0_q     <= w0_d;
              w1_q     <= w1_d;
              bias_q   <= bias_d;
              streak_q <= '0;
              conv_q   <= 1'b0;
              err_q    <= sat_inc8(err_q);
            end else begin
              streak_q <= streak_d;
              conv_q   <= (streak_d == STW'(CONV_COUNT));
            end
          end
        end
        RESP: begin
          if (bus.o_ready) begin
            ovld_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = (state_q == IDLE) && !load_req;
  assign bus.o_valid = ovld_q;
  assign bus.o_y     = y_q;
  assign bus.o_miss  = miss_q;
  assign w0_out      = w0_q;
  assign w1_out      = w1_q;
  assign bias_out    = bias_q;
  assign converged   = conv_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: arithmetic reference model, per-cycle compare, literal pins.
module tb_perceptron_trainer;

  logic clk;
  logic rst_n, rst_sat_n, freeze;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  perceptron_trainer_if #(.XW(4)) bus ();
  perceptron_trainer_if #(.XW(4)) bus_hi ();
  perceptron_trainer_if #(.XW(4)) bus_lo ();

  assign bus_hi.s_valid  = bus.s_valid;
  assign bus_hi.s_x0     = bus.s_x0;
  assign bus_hi.s_x1     = bus.s_x1;
  assign bus_hi.s_target = bus.s_target;
  assign bus_hi.o_ready  = bus.o_ready;
  assign bus_lo.s_valid  = bus.s_valid;
  assign bus_lo.s_x0     = bus.s_x0;
  assign bus_lo.s_x1     = bus.s_x1;
  assign bus_lo.s_target = bus.s_target;
  assign bus_lo.o_ready  = bus.o_ready;

  logic signed [5:0] w0, w1, bias, w0_hi, w1_hi, b_hi, w0_lo, w1_lo, b_lo;
  logic              conv, conv_hi, conv_lo;
  logic [7:0]        errc, err_hi, err_lo;

`ifdef TRAINER_WEIGHT_LOAD_EN
  logic              ld_en;
  logic signed [5:0] ld_w0, ld_w1, ld_bias;
`endif

  perceptron_trainer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .freeze(freeze),
`ifdef TRAINER_WEIGHT_LOAD_EN
    .ld_en(ld_en), .ld_w0(ld_w0), .ld_w1(ld_w1), .ld_bias(ld_bias),
`endif
    .w0_out(w0), .w1_out(w1), .bias_out(bias), .converged(conv), .err_cnt(errc)
  );

  perceptron_trainer #(.W0_INIT(30), .THRESH(1000)) u_hi (
    .clk(clk), .rst_n(rst_sat_n), .bus(bus_hi), .freeze(freeze),
`ifdef TRAINER_WEIGHT_LOAD_EN
    .ld_en(1'b0), .ld_w0(6'sd0), .ld_w1(6'sd0), .ld_bias(6'sd0),
`endif
    .w0_out(w0_hi), .w1_out(w1_hi), .bias_out(b_hi), .converged(conv_hi), .err_cnt(err_hi)
  );

  perceptron_trainer #(.W0_INIT(-30), .THRESH(-1000)) u_lo (
    .clk(clk), .rst_n(rst_sat_n), .bus(bus_lo), .freeze(freeze),
`ifdef TRAINER_WEIGHT_LOAD_EN
    .ld_en(1'b0), .ld_w0(6'sd0), .ld_w1(6'sd0), .ld_bias(6'sd0),
`endif
    .w0_out(w0_lo), .w1_out(w1_lo), .bias_out(b_lo), .converged(conv_lo), .err_cnt(err_lo)
  );

  int checks = 0;
  int errors = 0;

  // reference model of the default-parameter trainer
  int mw0, mw1, mb, mstreak, merr;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp6(input int v);
    if (v > 31)  return 31;
    if (v < -32) return -32;
    return v;
  endfunction

  task automatic model_reset();
    mw0 = 2; mw1 = 1; mb = 1; mstreak = 0; merr = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input int x0, input int x1, input int t);
    int  s, step;
    bit  y, miss;
    s    = mw0 * x0 + mw1 * x1 + mb;
    y    = (s > 6);
    miss = (y != t[0]);
    exp_q.push_back({y, miss});
    if (!freeze) begin
      if (miss) begin
        step    = (t != 0) ? 1 : -1;
        mw0     = clamp6(mw0 + step * x0);
        mw1     = clamp6(mw1 + step * x1);
        mb      = clamp6(mb + step);
        merr    = (merr < 255) ? merr + 1 : 255;
        mstreak = 0;
      end else if (mstreak < 8) begin
        mstreak++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_without_sample", exp_q.size(), 1);
      end else begin
        chk("o_y", bus.o_y, exp_q[0][1]);
        chk("o_miss", bus.o_miss, exp_q[0][0]);
        chk("w0", w0, mw0);
        chk("w1", w1, mw1);
        chk("bias", bias, mb);
        chk("err_cnt", errc, merr);
        chk("converged", conv, int'(mstreak == 8));
        chk("s_ready_in_resp", bus.s_ready, 0);
        if (bus.o_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_w0"}, w0, 2);
    chk({tag, "_w1"}, w1, 1);
    chk({tag, "_bias"}, bias, 1);
    chk({tag, "_o_valid"}, bus.o_valid, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
    chk({tag, "_err"}, errc, 0);
    chk({tag, "_conv"}, conv, 0);
    chk({tag, "_o_y"}, bus.o_y, 0);
    chk({tag, "_o_miss"}, bus.o_miss, 0);
  endtask

  task automatic send(input int x0, input int x1, input int t, input int hold,
                      output bit gy, output bit gm);
    int n;
    n = 0;
    while (!bus.s_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("s_ready_wait", bus.s_ready, 1);
    bus.s_valid  = 1'b1;
    bus.s_x0     = x0[3:0];
    bus.s_x1     = x1[3:0];
    bus.s_target = t[0];
    model_push(x0, x1, t);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    n = 1;
    while (!bus.o_valid && n < 12) begin
      @(posedge clk); #1; n++;
    end
    chk("latency_edges", n, 3);
    gy = bus.o_y;
    gm = bus.o_miss;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_o_valid", bus.o_valid, 1);
      chk("bp_s_ready", bus.s_ready, 0);
    end
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    bus.o_ready = 1'b0;
    chk("resp_done", bus.o_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gy, gm;
    rst_n = 1'b0; rst_sat_n = 1'b0; freeze = 1'b0;
    bus.s_valid = 1'b0; bus.s_x0 = '0; bus.s_x1 = '0; bus.s_target = 1'b0; bus.o_ready = 1'b0;
`ifdef TRAINER_WEIGHT_LOAD_EN
    ld_en = 1'b0; ld_w0 = '0; ld_w1 = '0; ld_bias = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset("rst0");

    // sample accepted, then reset during MAC discards it
    bus.s_valid = 1'b1; bus.s_x0 = 4'd3; bus.s_x1 = 4'd1; bus.s_target = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset("rst_mac");
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_resp_after_rst", bus.o_valid, 0);
    end

    // hit: 2*3 + 1*1 + 1 = 8 > 6
    send(3, 1, 1, 0, gy, gm);
    chk("hit_y", gy, 1); chk("hit_miss", gm, 0);
    chk("hit_w0", w0, 2); chk("hit_w1", w1, 1); chk("hit_b", bias, 1);

    // miss: 2 + 1 + 1 = 4 -> increment
    send(1, 1, 1, 0, gy, gm);
    chk("miss_y", gy, 0); chk("miss_miss", gm, 1);
    chk("miss_w0", w0, 3); chk("miss_w1", w1, 2); chk("miss_b", bias, 2); chk("miss_err", errc, 1);

    // 45 + 30 + 2 = 77 with target 0 -> decrement by 15,15,1, under backpressure
    send(15, 15, 0, 5, gy, gm);
    chk("dec_y", gy, 1); chk("dec_miss", gm, 1);
    chk("dec_w0", w0, -12); chk("dec_w1", w1, -13); chk("dec_b", bias, 1); chk("dec_err", errc, 2);

    // freeze: sum = 1, a miss but no learning
    freeze = 1'b1;
    send(0, 0, 1, 0, gy, gm);
    freeze = 1'b0;
    chk("frz_miss", gm, 1);
    chk("frz_w0", w0, -12); chk("frz_w1", w1, -13); chk("frz_b", bias, 1); chk("frz_err", errc, 2);

    // eight hits (all sums negative, target 0)
    for (int i = 0; i < 8; i++) begin
      send(i, 15 - i, 0, 0, gy, gm);
      if (i == 6) chk("conv_after7", conv, 0);
    end
    chk("conv_after8", conv, 1);
    send(0, 0, 1, 0, gy, gm);
    chk("conv_cleared", conv, 0); chk("unconv_b", bias, 2); chk("unconv_err", errc, 3);

    // saturation instances start learning from here
    rst_sat_n = 1'b1;
    @(posedge clk); #1;
    send(15, 0, 1, 0, gy, gm);
    chk("hi_w0_sat", w0_hi, 31); chk("hi_err", err_hi, 1);
    chk("lo_w0_hold", w0_lo, -30);
    send(15, 0, 0, 0, gy, gm);
    chk("hi_w0_stay", w0_hi, 31);
    chk("lo_w0_sat", w0_lo, -32); chk("lo_b", b_lo, 0); chk("lo_err", err_lo, 1);

`ifdef TRAINER_WEIGHT_LOAD_EN
    ld_en = 1'b1; ld_w0 = 6'sd5; ld_w1 = -6'sd3; ld_bias = 6'sd4;
    bus.s_valid = 1'b1;
    #1 chk("ld_blocks_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    ld_en = 1'b0; bus.s_valid = 1'b0;
    mw0 = 5; mw1 = -3; mb = 4; mstreak = 0;
    chk("ld_w0", w0, 5); chk("ld_w1", w1, -3); chk("ld_b", bias, 4);
    send(1, 1, 1, 0, gy, gm);
    chk("ld_then_y", gy, 0); chk("ld_then_w0", w0, 6);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
